alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 151 +++++++++++++++
 tb/tb_alu_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter in front of one shared combinational ALU.
// One operation is in flight at a time: IDLE (grant/capture) -> EXEC (ALU evaluates
// captured operands) -> RESP (result held until the granted requester takes it).
// Optional build macro: ALU_ARB_FIXED_PRIO_EN -- port 0 always wins contention and
// the last-grant pointer is not built.
module alu_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        Req_0,
   input  logic        Req_1,
   input  logic [3:0]  ALUOp_0,
   input  logic [31:0] A_0,
   input  logic [31:0] B_0,
   input  logic [4:0]  Shamt_0,
   input  logic [3:0]  ALUOp_1,
   input  logic [31:0] A_1,
   input  logic [31:0] B_1,
   input  logic [4:0]  Shamt_1,
   output logic        Ack_0,
   output logic        Ack_1,
   output logic        RspValid_0,
   output logic        RspValid_1,
   input  logic        RspReady_0,
   input  logic        RspReady_1,
   output logic [31:0] RspResult,
   output logic        RspZero,
   output logic        RspErr,
   output logic [3:0]  ALUOperation,
   output logic [31:0] ALUA,
   output logic [31:0] ALUB,
   output logic [4:0]  ALUShamt,
   input  logic [31:0] ALUResult,
   input  logic        ALUZero,
   output logic        Busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]  state_q, state_d;
   logic        gnt_q;        // port that owns the operation in flight
   logic        win1;         // port 1 wins this IDLE cycle
   logic        grant_any;
   logic        done;         // response handshake on the granted port
   logic [3:0]  op_q;
   logic [31:0] a_q, b_q;
   logic [4:0]  sh_q;
   logic [31:0] res_q;
   logic        zero_q, err_q;

   // Opcodes the shared ALU implements; anything else is answered with an error.
   function automatic logic op_legal(input logic [3:0] op);
      case (op)
         4'b0000, 4'b0001, 4'b0010, 4'b0011,
         4'b0100, 4'b0101, 4'b1000: op_legal = 1'b1;
         default:                   op_legal = 1'b0;
      endcase
   endfunction

`ifdef ALU_ARB_FIXED_PRIO_EN
   // Fixed priority: port 1 only wins when port 0 is not asking.
   always_comb begin
      grant_any = (state_q == S_IDLE) && reset && (Req_0 || Req_1);
      win1      = Req_1 && !Req_0;
   end
`else
   logic ptr_q;               // last port that completed an operation

   // Round-robin: on contention the port not served last wins.
   always_comb begin
      grant_any = (state_q == S_IDLE) && reset && (Req_0 || Req_1);
      win1      = Req_1 && (!Req_0 || !ptr_q);
   end

   // Pointer moves only when a response is actually handed over.
   always_ff @(posedge clk) begin
      if (!reset)    ptr_q <= 1'b1;
      else if (done) ptr_q <= gnt_q;
   end
`endif

   assign Ack_0      = grant_any && !win1;
   assign Ack_1      = grant_any && win1;
   assign done       = (state_q == S_RESP) && (gnt_q ? RspReady_1 : RspReady_0);
   assign RspValid_0 = (state_q == S_RESP) && !gnt_q;
   assign RspValid_1 = (state_q == S_RESP) && gnt_q;
   assign Busy       = (state_q != S_IDLE);

   assign ALUOperation = op_q;
   assign ALUA         = a_q;
   assign ALUB         = b_q;
   assign ALUShamt     = sh_q;
   assign RspResult    = res_q;
   assign RspZero      = zero_q;
   assign RspErr       = err_q;

   // Next-state logic for the IDLE/EXEC/RESP sequence.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (grant_any) state_d = S_EXEC;
         S_EXEC:  state_d = S_RESP;
         S_RESP:  if (done) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Control state: FSM and owner of the current operation.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         gnt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (grant_any) gnt_q <= win1;
      end
   end

   // Operand capture on grant and response capture at the end of EXEC.
   always_ff @(posedge clk) begin
      if (!reset) begin
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         sh_q   <= '0;
         res_q  <= '0;
         zero_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         if (grant_any) begin
            op_q <= win1 ? ALUOp_1 : ALUOp_0;
            a_q  <= win1 ? A_1     : A_0;
            b_q  <= win1 ? B_1     : B_0;
            sh_q <= win1 ? Shamt_1 : Shamt_0;
         end
         if (state_q == S_EXEC) begin
            if (op_legal(op_q)) begin
               res_q  <= ALUResult;
               zero_q <= ALUZero;
               err_q  <= 1'b0;
            end else begin
               res_q  <= '0;
               zero_q <= 1'b1;
               err_q  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter; also models the shared combinational ALU.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        Req_0 = 1'b0, Req_1 = 1'b0;
   logic [3:0]  ALUOp_0 = '0, ALUOp_1 = '0;
   logic [31:0] A_0 = '0, B_0 = '0, A_1 = '0, B_1 = '0;
   logic [4:0]  Shamt_0 = '0, Shamt_1 = '0;
   logic        Ack_0, Ack_1, RspValid_0, RspValid_1;
   logic        RspReady_0 = 1'b0, RspReady_1 = 1'b0;
   logic [31:0] RspResult;
   logic        RspZero, RspErr;
   logic [3:0]  ALUOperation;
   logic [31:0] ALUA, ALUB;
   logic [4:0]  ALUShamt;
   logic [31:0] ALUResult;
   logic        ALUZero;
   logic        Busy;

   int checks = 0;
   int errors = 0;
   int last_g = 1;

   always #5 clk = ~clk;

   alu_arbiter dut (
      .clk(clk), .reset(reset),
      .Req_0(Req_0), .Req_1(Req_1),
      .ALUOp_0(ALUOp_0), .A_0(A_0), .B_0(B_0), .Shamt_0(Shamt_0),
      .ALUOp_1(ALUOp_1), .A_1(A_1), .B_1(B_1), .Shamt_1(Shamt_1),
      .Ack_0(Ack_0), .Ack_1(Ack_1),
      .RspValid_0(RspValid_0), .RspValid_1(RspValid_1),
      .RspReady_0(RspReady_0), .RspReady_1(RspReady_1),
      .RspResult(RspResult), .RspZero(RspZero), .RspErr(RspErr),
      .ALUOperation(ALUOperation), .ALUA(ALUA), .ALUB(ALUB), .ALUShamt(ALUShamt),
      .ALUResult(ALUResult), .ALUZero(ALUZero), .Busy(Busy)
   );

   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sh);
      case (op)
         4'b0000: alu_f = a & b;
         4'b0001: alu_f = a | b;
         4'b0010: alu_f = a ^ b;
         4'b0011: alu_f = a + b;
         4'b0100: alu_f = b << sh;
         4'b0101: alu_f = b >> sh;
         4'b1000: alu_f = a - b;
         default: alu_f = 32'hDEADBEEF;
      endcase
   endfunction

   assign ALUResult = alu_f(ALUOperation, ALUA, ALUB, ALUShamt);
   assign ALUZero   = (ALUResult == 32'd0);

   // Expected {err, zero, result} for one operation.
   function automatic logic [33:0] exp_rsp(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
      logic [31:0] r;
      if (!(op inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b1000}))
         return {1'b1, 1'b1, 32'd0};
      r = alu_f(op, a, b, sh);
      return {1'b0, (r == 32'd0), r};
   endfunction

   // Expected winner given current requests and last completed grant.
   function automatic int exp_grant(input logic r0, input logic r1, input int last);
      if (r0 && r1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         return 0;
`else
         return (last == 0) ? 1 : 0;
`endif
      end
      return r0 ? 0 : 1;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0; Req_0 = 1'b0; Req_1 = 1'b0; RspReady_0 = 1'b0; RspReady_1 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      last_g = 1;
   endtask

   // Runs one transaction from the current IDLE sample point; returns observations.
   task automatic txn(input int hold, input bit raise1, output int gp, output bit tim_ok,
                      output logic [31:0] res, output logic z, output logic e,
                      output bit stab_ok, output bit busy_ok);
      gp = -1; tim_ok = 1'b1; stab_ok = 1'b1; busy_ok = 1'b1; res = '0; z = 1'b0; e = 1'b0;
      for (int k = 0; k < 8; k++) begin
         #1;
         if (Ack_0 || Ack_1) break;
         @(negedge clk);
      end
      if (!(Ack_0 || Ack_1)) return;
      gp = (Ack_0 && Ack_1) ? 2 : (Ack_1 ? 1 : 0);
      if (Busy) busy_ok = 1'b0;
      if (gp == 2) return;
      @(negedge clk);
      if (gp == 0) begin Req_0 = 1'b0; RspReady_0 = (hold == 0); RspReady_1 = 1'b1; end
      else         begin Req_1 = 1'b0; RspReady_1 = (hold == 0); RspReady_0 = 1'b1; end
      if (raise1) Req_1 = 1'b1;
      #1;
      if (RspValid_0 || RspValid_1) tim_ok = 1'b0;
      if (!Busy || Ack_0 || Ack_1) busy_ok = 1'b0;
      @(negedge clk);
      #1;
      if (gp == 0 ? !(RspValid_0 && !RspValid_1) : !(RspValid_1 && !RspValid_0)) tim_ok = 1'b0;
      res = RspResult; z = RspZero; e = RspErr;
      for (int k = 0; k < hold; k++) begin
         if (Ack_0 || Ack_1 || !Busy) busy_ok = 1'b0;
         @(negedge clk);
         if (k == hold - 1) begin
            if (gp == 0) RspReady_0 = 1'b1; else RspReady_1 = 1'b1;
         end
         #1;
         if (gp == 0 ? !(RspValid_0 && !RspValid_1) : !(RspValid_1 && !RspValid_0)) stab_ok = 1'b0;
         if (RspResult !== res || RspZero !== z || RspErr !== e) stab_ok = 1'b0;
      end
      @(negedge clk);
      RspReady_0 = 1'b0; RspReady_1 = 1'b0;
      #1;
      if (RspValid_0 || RspValid_1) tim_ok = 1'b0;
      if (Busy) busy_ok = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
      checks++; if ({RspValid_0, RspValid_1, Ack_0, Ack_1} !== 4'b0) begin
         errors++; $display("FAIL reset_hs: got %b want 0000", {RspValid_0, RspValid_1, Ack_0, Ack_1}); end
      checks++; if ({RspResult, RspZero, RspErr} !== 34'd0) begin
         errors++; $display("FAIL reset_rsp: got %h/%b/%b want 0/0/0", RspResult, RspZero, RspErr); end
      checks++; if ({ALUOperation, ALUA, ALUB, ALUShamt} !== 73'd0) begin
         errors++; $display("FAIL reset_alu_drive: got %h %h %h %h want zeros", ALUOperation, ALUA, ALUB, ALUShamt); end
   endtask

   task automatic test_basic();
      int gp; bit t, s, b; logic [31:0] r; logic z, e;
      ALUOp_0 = 4'b0011; A_0 = 32'd5; B_0 = 32'd7; Shamt_0 = 5'd0; Req_0 = 1'b1;
      txn(0, 1'b0, gp, t, r, z, e, s, b);
      checks++; if (gp !== 0) begin errors++; $display("FAIL basic_grant: got %0d want 0", gp); end
      checks++; if (t !== 1'b1) begin errors++; $display("FAIL basic_latency: got %b want 1", t); end
      checks++; if ({r, z, e} !== {32'd12, 1'b0, 1'b0}) begin
         errors++; $display("FAIL basic_rsp: got %h/%b/%b want 0000000c/0/0", r, z, e); end
      checks++; if (ALUA !== 32'd5 || ALUB !== 32'd7) begin
         errors++; $display("FAIL basic_hold_operands: got %h %h want 5 7", ALUA, ALUB); end
      checks++; if (b !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", b); end
   endtask

   task automatic test_shift_add();
      int gp; bit t, s, b; logic [31:0] r; logic z, e;
      ALUOp_1 = 4'b0100; A_1 = 32'h1234; B_1 = 32'd1; Shamt_1 = 5'd31; Req_1 = 1'b1;
      txn(1, 1'b0, gp, t, r, z, e, s, b);
      checks++; if (gp !== 1) begin errors++; $display("FAIL sll_grant: got %0d want 1", gp); end
      checks++; if ({r, z, e} !== {32'h80000000, 1'b0, 1'b0}) begin
         errors++; $display("FAIL sll_rsp: got %h/%b/%b want 80000000/0/0", r, z, e); end
      ALUOp_0 = 4'b0011; A_0 = 32'hFFFFFFFF; B_0 = 32'd1; Req_0 = 1'b1;
      txn(0, 1'b0, gp, t, r, z, e, s, b);
      checks++; if (gp !== 0) begin errors++; $display("FAIL wrap_grant: got %0d want 0", gp); end
      checks++; if ({r, z, e} !== {32'd0, 1'b1, 1'b0}) begin
         errors++; $display("FAIL wrap_rsp: got %h/%b/%b want 0/1/0", r, z, e); end
   endtask

   task automatic test_illegal();
      int gp; bit t, s, b; logic [31:0] r; logic z, e;
      ALUOp_0 = 4'b0111; A_0 = 32'h55; B_0 = 32'h66; Req_0 = 1'b1;
      txn(0, 1'b0, gp, t, r, z, e, s, b);
      checks++; if ({r, z, e} !== {32'd0, 1'b1, 1'b1}) begin
         errors++; $display("FAIL illegal_rsp: got %h/%b/%b want 0/1/1", r, z, e); end
   endtask

   task automatic test_backpressure();
      int gp; bit t, s, b; logic [31:0] r; logic z, e;
      ALUOp_0 = 4'b1000; A_0 = 32'd100; B_0 = 32'd1; Req_0 = 1'b1;
      ALUOp_1 = 4'b0001; A_1 = 32'hF0; B_1 = 32'h0F;
      txn(5, 1'b1, gp, t, r, z, e, s, b);
      checks++; if (gp !== 0) begin errors++; $display("FAIL bp_grant: got %0d want 0", gp); end
      checks++; if (s !== 1'b1) begin errors++; $display("FAIL bp_stable: got %b want 1", s); end
      checks++; if (b !== 1'b1) begin errors++; $display("FAIL bp_no_ack_busy: got %b want 1", b); end
      checks++; if ({r, z, e} !== {32'd99, 1'b0, 1'b0}) begin
         errors++; $display("FAIL bp_rsp: got %h/%b/%b want 63/0/0", r, z, e); end
      checks++; if (Ack_1 !== 1'b1) begin errors++; $display("FAIL bp_ack1_after: got %b want 1", Ack_1); end
      txn(0, 1'b0, gp, t, r, z, e, s, b);
      checks++; if (gp !== 1 || r !== 32'hFF) begin
         errors++; $display("FAIL bp_second: got port %0d result %h want 1 000000ff", gp, r); end
   endtask

   task automatic test_rr();
      int gp, eg, rem0, rem1; bit t, s, b; logic [31:0] r; logic z, e;
      do_reset();
      ALUOp_0 = 4'b0011; A_0 = 32'd1; B_0 = 32'd1;
      ALUOp_1 = 4'b0010; A_1 = 32'd3; B_1 = 32'd5;
      Req_0 = 1'b1; Req_1 = 1'b1; rem0 = 4; rem1 = 4;
      for (int i = 0; i < 8; i++) begin
         eg = exp_grant(Req_0, Req_1, last_g);
         txn(0, 1'b0, gp, t, r, z, e, s, b);
         checks++; if (gp !== eg || t !== 1'b1) begin
            errors++; $display("FAIL rr_order[%0d]: got port %0d timing %b want port %0d timing 1", i, gp, t, eg); end
         checks++; if (r !== (eg == 0 ? 32'd2 : 32'd6)) begin
            errors++; $display("FAIL rr_rsp[%0d]: got %h want %h", i, r, (eg == 0 ? 32'd2 : 32'd6)); end
         last_g = eg;
         if (eg == 0) begin rem0--; if (rem0 > 0) Req_0 = 1'b1; end
         else         begin rem1--; if (rem1 > 0) Req_1 = 1'b1; end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      ALUOp_0 = 4'b0011; A_0 = 32'd9; B_0 = 32'd9; Req_0 = 1'b1;
      #1;
      checks++; if (Ack_0 !== 1'b1) begin errors++; $display("FAIL rstx_ack: got %b want 1", Ack_0); end
      @(negedge clk); Req_0 = 1'b0; reset = 1'b0;
      @(negedge clk); reset = 1'b1; #1;
      checks++; if ({Busy, RspValid_0, RspValid_1} !== 3'b0) begin
         errors++; $display("FAIL rst_exec: got %b want 000", {Busy, RspValid_0, RspValid_1}); end
      Req_0 = 1'b1;
      #1;
      @(negedge clk); Req_0 = 1'b0;
      @(negedge clk); #1;
      checks++; if (RspValid_0 !== 1'b1 || RspResult !== 32'd18) begin
         errors++; $display("FAIL rstr_pre: got valid %b result %h want 1 00000012", RspValid_0, RspResult); end
      reset = 1'b0;
      @(negedge clk); reset = 1'b1; #1;
      checks++; if ({Busy, RspValid_0, RspValid_1} !== 3'b0 || RspResult !== 32'd0) begin
         errors++; $display("FAIL rst_resp: got %b result %h want 000 0", {Busy, RspValid_0, RspValid_1}, RspResult); end
      RspReady_0 = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (RspValid_0 !== 1'b0 || Busy !== 1'b0) begin
         errors++; $display("FAIL rst_no_late_rsp: got valid %b busy %b want 0 0", RspValid_0, Busy); end
      RspReady_0 = 1'b0;
      last_g = 1;
   endtask

   task automatic rand_op(output logic [3:0] op, output logic [31:0] a, output logic [31:0] b,
                          output logic [4:0] sh);
      logic [3:0] lg [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8};
      logic [3:0] il [9] = '{4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
      op = ($urandom_range(0, 9) < 8) ? lg[$urandom_range(0, 6)] : il[$urandom_range(0, 8)];
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      sh = 5'($urandom_range(0, 31));
   endtask

   task automatic test_random();
      int gp, eg, hold; bit t, s, b; logic [31:0] r; logic z, e; logic [33:0] ex;
      do_reset();
      for (int i = 0; i < 30; i++) begin
         if (!Req_0 && $urandom_range(0, 1)) begin rand_op(ALUOp_0, A_0, B_0, Shamt_0); Req_0 = 1'b1; end
         if (!Req_1 && $urandom_range(0, 1)) begin rand_op(ALUOp_1, A_1, B_1, Shamt_1); Req_1 = 1'b1; end
         if (!Req_0 && !Req_1) begin rand_op(ALUOp_0, A_0, B_0, Shamt_0); Req_0 = 1'b1; end
         eg = exp_grant(Req_0, Req_1, last_g);
         ex = (eg == 0) ? exp_rsp(ALUOp_0, A_0, B_0, Shamt_0) : exp_rsp(ALUOp_1, A_1, B_1, Shamt_1);
         hold = $urandom_range(0, 3);
         txn(hold, 1'b0, gp, t, r, z, e, s, b);
         checks++; if (gp !== eg) begin errors++; $display("FAIL rnd_grant[%0d]: got %0d want %0d", i, gp, eg); end
         checks++; if ({e, z, r} !== ex) begin
            errors++; $display("FAIL rnd_rsp[%0d]: got %b/%b/%h want %b/%b/%h", i, e, z, r, ex[33], ex[32], ex[31:0]); end
         checks++; if ({t, s, b} !== 3'b111) begin
            errors++; $display("FAIL rnd_proto[%0d]: got timing/stable/busy %b want 111", i, {t, s, b}); end
         last_g = eg;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_shift_add();
      test_illegal();
      test_backpressure();
      test_rr();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
